// File: rtl/data_mem_access.sv
// Load/store unit between the pipeline and a single-port word memory.
// Sub-word stores use read-modify-write; responses are one-cycle registered pulses.
module data_mem_access #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_oob;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_oob    = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
  assign w_err    = (req_size == 2'b11)
                 || ((req_size == 2'b01) && req_addr[0])
                 || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                 || w_oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err)                   w_next = RESP;
          else if (!req_we)            w_next = LOAD;
          else if (req_size == 2'b10)  w_next = STORE;
          else                         w_next = RMW_RD;
        end
      end
      LOAD:    w_next = RESP;
      RMW_RD:  w_next = STORE;
      STORE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latched request; sub-word store data is widened to the merged word in RMW_RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= '0;
      r_off    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_signed <= req_signed;
      r_size   <= req_size;
      r_off    <= req_addr[1:0];
      r_addr   <= {req_addr[31:2], 2'b00};
      r_wdata  <= req_wdata;
    end else if (r_state == RMW_RD) begin
      r_wdata  <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      if (w_accept && w_err) r_err   <= 1'b1;
      if (r_state == LOAD)   r_rdata <= w_load;
    end
  end

  assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load = mem_rdata;
    if (r_size == 2'b00)
      w_load = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
    else if (r_size == 2'b01)
      w_load = r_signed ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
  end

  always_comb begin
    w_merged = mem_rdata;
    if (r_size == 2'b00)
      w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    else if (r_off[1])
      w_merged[31:16] = r_wdata[15:0];
    else
      w_merged[15:0] = r_wdata[15:0];
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_we     = (r_state == STORE) && r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = mem_we ? r_wdata : '0;

endmodule

// File: tb/tb_data_mem_access.sv
// Randomized bench for data_mem_access: word-array reference model with per-cycle
// expected outputs, plus literal checks for the documented example transactions.
module tb_data_mem_access;

  localparam int unsigned MW = 64;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  data_mem_access #(.MEM_WORDS(MW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] init_val(input int unsigned i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Attached memory as the DUT sees it; the model keeps its own copy in ref_mem.
  logic [31:0] tb_mem [MW];
  logic [31:0] ref_mem [MW];
  bit          loaded = 1'b0;

  assign mem_rdata = ((mem_addr >> 2) < MW) ? tb_mem[mem_addr[7:2]] : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < MW; i++) tb_mem[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (mem_we && ((mem_addr >> 2) < MW)) begin
      tb_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic        exp_ready, exp_rv, exp_err, exp_we;
  logic [31:0] exp_rdata, exp_wdata, exp_addr;

  always @(negedge clk) begin
    chk("req_ready",  {31'b0, req_ready},  {31'b0, exp_ready});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_rv});
    chk("resp_err",   {31'b0, resp_err},   {31'b0, exp_err});
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("mem_we",     {31'b0, mem_we},     {31'b0, exp_we});
    chk("mem_wdata",  mem_wdata, exp_wdata);
    chk("mem_addr",   mem_addr,  exp_addr);
  end

  task automatic set_idle_exp();
    exp_ready = 1'b1; exp_rv = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
    exp_rdata = '0;   exp_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    set_idle_exp();
    repeat (n) next_cycle();
  endtask

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
        || ((a >> 2) >= MW);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input bit sg, input int unsigned off);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'b01) begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] d, input int unsigned off);
    logic [31:0] m;
    if (sz == 2'b10) return d;
    m = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << (8 * off);
    return (w & ~m) | ((d << (8 * off)) & m);
  endfunction

  logic [31:0] cap_rdata, cap_wdata;
  logic        cap_err;
  int          cap_we_n, cap_we_at;

  // One transaction; hold=1 keeps req_valid high with junk fields while busy.
  task automatic do_req(input bit we, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] d, input bit hold);
    int          lat;
    bit          err;
    int unsigned wi, off;
    logic [31:0] rd, mg;
    err = model_err(sz, a);
    wi  = int'(a[7:2]);
    off = int'(a[1:0]);
    rd  = '0;
    mg  = '0;
    if (err)          lat = 1;
    else if (!we) begin
      lat = 2;
      rd  = model_load(ref_mem[wi], sz, sg, off);
    end else begin
      lat = (sz == 2'b10) ? 2 : 3;
      mg  = model_merge(ref_mem[wi], sz, d, off);
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    set_idle_exp();
    next_cycle();
    exp_addr  = {a[31:2], 2'b00};
    cap_we_n  = 0;
    cap_we_at = 0;
    for (int k = 1; k <= lat; k++) begin
      if (hold) begin
        req_valid = 1'b1; req_we = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      exp_ready = 1'b0;
      exp_rv    = (k == lat);
      exp_err   = (k == lat) && err;
      exp_rdata = (k == lat) ? rd : '0;
      exp_we    = we && !err && (k == lat - 1);
      exp_wdata = exp_we ? mg : '0;
      if (mem_we) begin cap_we_n++; cap_we_at = k; cap_wdata = mem_wdata; end
      if (k == lat) begin cap_rdata = resp_rdata; cap_err = resp_err; end
      next_cycle();
    end
    req_valid = 1'b0;
    set_idle_exp();
    if (we && !err) ref_mem[wi] = mg;
  endtask

  task automatic sb_reset_in_store(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mg;
    mg = model_merge(ref_mem[int'(a[7:2])], 2'b00, d, int'(a[1:0]));
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = a; req_wdata = d;
    set_idle_exp();
    next_cycle();
    req_valid = 1'b0;
    exp_addr  = {a[31:2], 2'b00};
    exp_ready = 1'b0;
    next_cycle();
    exp_we    = 1'b1;
    exp_wdata = mg;
    chk("sb_store_we", {31'b0, mem_we}, 32'd1);
    chk("sb_store_wdata", mem_wdata, mg);
    set_idle_exp();
    exp_addr = '0;
    rst_n    = 1'b0;
    #1;
    chk("rst_we_drop", {31'b0, mem_we}, 32'd0);
    chk("rst_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    bit          hold;
    for (int i = 0; i < MW; i++) ref_mem[i] = init_val(i);
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    set_idle_exp();
    exp_addr = '0;
    repeat (3) next_cycle();
    rst_n = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h8899AABB, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 1'b0);
    chk("lb_signed_lit", cap_rdata, 32'hFFFFFF88);
    do_req(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 1'b0);
    chk("lbu_lit", cap_rdata, 32'h00000088);

    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000DEAD, 1'b0);
    chk("sh_we_count", cap_we_n, 32'd1);
    chk("sh_we_cycle", cap_we_at, 32'd2);
    chk("sh_wdata_lit", cap_wdata, 32'hDEAD3344);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
    chk("lw_after_sh_lit", cap_rdata, 32'hDEAD3344);

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0);
    chk("sw_we_cycle", cap_we_at, 32'd1);
    chk("sw_rdata_zero", cap_rdata, 32'h0);

    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0);
    chk("err_lw_mis", {31'b0, cap_err}, 32'd1);
    do_req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1'b0);
    chk("err_lh_mis", {31'b0, cap_err}, 32'd1);
    do_req(1'b1, 2'b11, 1'b0, 32'h08, 32'h12345678, 1'b0);
    chk("err_size3", {31'b0, cap_err}, 32'd1);
    chk("err_size3_no_we", cap_we_n, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, MW * 4, 32'h0, 1'b0);
    chk("err_oob", {31'b0, cap_err}, 32'd1);

    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1);
    do_req(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 1'b1);

    sb_reset_in_store(32'h21, 32'h000000A5);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("sb_abandoned", cap_rdata, init_val(8));

    for (int t = 0; t < 300; t++) begin
      sz = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 99) < 5) begin
        a = $urandom;
      end else begin
        a = 32'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, MW + 3)) * 4;
        if (sz == 2'b00)                     a = a + 32'($urandom_range(0, 3));
        else if ($urandom_range(0, 9) == 0)  a = a + 32'($urandom_range(1, 3));
        else if (sz == 2'b01)                a = a + 32'(2 * $urandom_range(0, 1));
      end
      hold = 1'($urandom);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, hold);
      if (!hold) idle($urandom_range(0, 2));
    end

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_access.md
DATA_MEM_ACCESS -- requirements
Module: data_mem_access

Interface
REQ-001 Parameter MEM_WORDS, default 1024, shall give the number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  shall be the asynchronous active-low reset.
REQ-004 req_valid  input  1  shall indicate that a pipeline memory request is present.
REQ-005 req_ready  output  1  shall indicate that the unit accepts a request this cycle.
REQ-006 req_we  input  1  shall select store (1) or load (0).
REQ-007 req_size  input  2  shall select the access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_signed  input  1  shall select sign-extension for byte and halfword loads.
REQ-009 req_addr  input  32  shall carry the byte address.
REQ-010 req_wdata  input  32  shall carry store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-011 resp_valid  output  1  shall be a one-cycle completion pulse.
REQ-012 resp_rdata  output  32  shall carry load data; 0 for stores and errors.
REQ-013 resp_err  output  1  shall flag a misaligned, illegal-size or out-of-range request; valid with resp_valid.
REQ-014 mem_we  output  1  shall be the write enable to the data memory.
REQ-015 mem_addr  output  32  shall be the word-aligned byte address to the data memory ({addr[31:2],2'b00}).
REQ-016 mem_wdata  output  32  shall be the full write word to the data memory.
REQ-017 mem_rdata  input  32  shall be the combinational read word from the data memory at mem_addr.

Function
REQ-018 The FSM shall have states IDLE, LOAD, RMW_RD, STORE and RESP.
REQ-019 req_ready shall be 1 only in IDLE; req_valid outside IDLE shall be ignored.
REQ-020 On req_valid&&req_ready, the unit shall latch we, size, signed, addr and wdata, and leave IDLE.
REQ-021 Error checks at acceptance: size 11; halfword with addr[0]=1; word with addr[1:0]!=0; addr[31:2]>=MEM_WORDS.
REQ-022 If any check in REQ-021 fails: next state RESP, resp_err=1, no memory access; mem_we shall stay 0.
REQ-023 Load: IDLE->LOAD->RESP; capture mem_rdata in LOAD; resp_valid 2 cycles after acceptance.
REQ-024 Word store: IDLE->STORE->RESP; mem_we=1 for exactly the STORE cycle; resp_valid 2 cycles after acceptance.
REQ-025 Byte/halfword store: IDLE->RMW_RD->STORE->RESP.
REQ-026 In RMW_RD the unit shall capture mem_rdata, replace only the addressed lanes, and keep all other lanes unchanged.
REQ-027 In STORE the unit shall write the merged word; resp_valid 3 cycles after acceptance.
REQ-028 Lanes shall be little-endian: byte k = bits [8k+7:8k]; halfword at offset 0 = [15:0], at offset 2 = [31:16].
REQ-029 Load extraction: shift the addressed lane to bit 0; zero- or sign-extend per the latched signed bit; word loads are unmodified.
REQ-030 mem_we shall be 1 only in STORE, and mem_wdata shall be 0 outside STORE.
REQ-031 mem_addr shall hold the latched aligned address from acceptance until the next acceptance.
REQ-032 RESP shall last one cycle and then return to IDLE; req_ready shall be 0 in RESP, so back-to-back requests are spaced at least one cycle apart.
REQ-033 resp_rdata and resp_err shall be registered and shall be 0 whenever resp_valid=0.

Reset
REQ-034 rst_n=0 shall immediately force IDLE with req_ready=1 and resp_valid, resp_err, mem_we=0; resp_rdata, mem_addr, mem_wdata and latched fields shall be 0.
REQ-035 A reset asserted mid-operation, including during STORE, shall drop mem_we in the same cycle, abandon the request, and produce no resp_valid.
REQ-036 After release, the first request shall be acceptable on the first rising edge with rst_n=1.

Verification
REQ-037 Word 0x40 = 0x8899AABB; LB addr 0x43 signed -> resp_rdata 0xFFFFFF88 at acceptance+2; LBU -> 0x00000088.
REQ-038 Word 0x40 = 0x11223344; SH addr 0x42 wdata 0xDEAD -> single mem_we pulse at acceptance+2 with mem_wdata 0xDEAD3344; resp_valid at +3.
REQ-039 SW addr 0x10 wdata 0xCAFEF00D -> mem_we=1 only at +1 with mem_addr 0x10; resp_valid at +2, resp_rdata 0.
REQ-040 LW addr 0x06, LH addr 0x03, size 11, and LW addr MEM_WORDS*4 -> each gives resp_err=1 at +1, and mem_we stays 0 throughout.
REQ-041 Hold req_valid=1 through a load -> exactly one acceptance per IDLE cycle, with req_ready low in LOAD and RESP.
REQ-042 Assert rst_n=0 during the STORE cycle of an SB -> mem_we falls immediately, no resp_valid, and req_ready=1 after release.
